// File: rtl/pll_drp_regs_if.sv
// ---------------------------------------------------------------------------
// pll_drp_regs_if
//   DRP bus bundle between a DRP master (PLL top level or test driver) and
//   the pll_drp_regs register file. Signal names follow the DRP convention.
//
//   DADDR [6:0]  register address            (master -> slave)
//   DEN          access enable, one per cycle (master -> slave)
//   DWE          write enable, qualified by DEN (master -> slave)
//   DI    [15:0] write data                  (master -> slave)
//   DO    [15:0] read data, valid with DRDY  (slave -> master)
//   DRDY         one-cycle access-complete   (slave -> master)
// ---------------------------------------------------------------------------
interface pll_drp_regs_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
  modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);
endinterface

// File: rtl/pll_drp_regs.sv
// ---------------------------------------------------------------------------
// pll_drp_regs
//   DRP register file for the PLL simulation model. Stores the 16-bit
//   configuration words (addresses 0x06..0x16) and decodes them into
//   per-output divide, duty-cycle x1000 and phase-in-degrees values, plus
//   the feedback multiplier x1000, feedback phase and input divider.
//   A channel's decoded outputs read 0 until one of its registers has been
//   written, meaning "not dynamically set".
//
//   DCLK        DRP clock, rising edge
//   RST         asynchronous active-low reset
//   drp         DRP bus (slave side): DADDR/DEN/DWE/DI in, DO/DRDY out
//   CLKOUTn_*   decoded divide / duty x1000 / phase for outputs 0..6
//   CLKFBOUT_*  decoded feedback multiply x1000 / phase
//   DIVCLK_DIVIDE decoded input divider
// ---------------------------------------------------------------------------
module pll_drp_regs (
  input  logic                DCLK,
  input  logic                RST,
  pll_drp_regs_if.slave       drp,
  output logic [31:0]         CLKOUT0_DIVIDE,
  output logic [31:0]         CLKOUT0_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT0_PHASE,
  output logic [31:0]         CLKOUT1_DIVIDE,
  output logic [31:0]         CLKOUT1_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT1_PHASE,
  output logic [31:0]         CLKOUT2_DIVIDE,
  output logic [31:0]         CLKOUT2_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT2_PHASE,
  output logic [31:0]         CLKOUT3_DIVIDE,
  output logic [31:0]         CLKOUT3_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT3_PHASE,
  output logic [31:0]         CLKOUT4_DIVIDE,
  output logic [31:0]         CLKOUT4_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT4_PHASE,
  output logic [31:0]         CLKOUT5_DIVIDE,
  output logic [31:0]         CLKOUT5_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT5_PHASE,
  output logic [31:0]         CLKOUT6_DIVIDE,
  output logic [31:0]         CLKOUT6_DUTY_CYCLE_1000,
  output logic [31:0]         CLKOUT6_PHASE,
  output logic [31:0]         CLKFBOUT_MULT_F_1000,
  output logic [31:0]         CLKFBOUT_PHASE,
  output logic [31:0]         DIVCLK_DIVIDE
);

  // Storage slot = DADDR - 0x06. Register pairs occupy slots 2c/2c+1 for
  // channel slot c: 0=CLKOUT5 1=CLKOUT0 2=CLKOUT1 3=CLKOUT2 4=CLKOUT3
  // 5=CLKOUT4 6=CLKOUT6 7=CLKFBOUT; DIVCLK is the lone slot 16 (flag 8).
  localparam int unsigned NUM_REGS  = 17;
  localparam int unsigned NUM_FLAGS = 9;

  logic [15:0]          regs_q [NUM_REGS];
  logic [15:0]          regs_d [NUM_REGS];
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 drdy_q, drdy_d;
  logic [15:0]          do_q, do_d;

  logic [6:0] addr_off;
  logic       addr_mapped;
  logic [4:0] slot;

  // HIGH/LOW count field: 0 encodes 64.
  function automatic logic [31:0] field_val(input logic [5:0] f);
    return (f == 6'd0) ? 32'd64 : {26'd0, f};
  endfunction

  function automatic logic [31:0] count_d(input logic [5:0] high_f,
                                          input logic [5:0] low_f,
                                          input logic       no_count);
    return no_count ? 32'd1 : field_val(high_f) + field_val(low_f);
  endfunction

  function automatic logic [31:0] phase_deg(input logic [2:0]  phase_mux,
                                            input logic [5:0]  delay,
                                            input logic [31:0] d);
    return ((32'd8 * {26'd0, delay} + {29'd0, phase_mux}) * 32'd45) / d;
  endfunction

  // -------------------------------------------------------------------------
  // Bus access: write/read decode and response generation
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its default before any conditional assignment
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    regs_d      = regs_q;
    flags_d     = flags_q;
    drdy_d      = drp.DEN;
    do_d        = '0;
    // Addresses below 0x06 wrap to large offsets, so one compare covers both
    // ends of the mapped window.
    addr_off    = drp.DADDR - 7'd6;
    addr_mapped = (addr_off <= 7'd16);
    slot        = addr_off[4:0];
    if (drp.DEN && addr_mapped) begin
      if (drp.DWE) begin
        regs_d[slot]        = drp.DI;
        flags_d[slot[4:1]]  = 1'b1;
      end else begin
        do_d = regs_q[slot];
      end
    end
  end

  // NOTE: the register storage is reset along with the control flops because
  // the decoded outputs must read 0 straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its _d input.
  always_ff @(posedge DCLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
      drdy_q  <= 1'b0;
      do_q    <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
      drdy_q  <= drdy_d;
      do_q    <= do_d;
    end
  end

  assign drp.DRDY = drdy_q;
  assign drp.DO   = do_q;

  // -------------------------------------------------------------------------
  // Output channel decode (CLKOUT slots 0..6)
  // -------------------------------------------------------------------------
  logic [31:0] ch_div   [7];
  logic [31:0] ch_duty  [7];
  logic [31:0] ch_phase [7];

  for (genvar g = 0; g < 7; g++) begin : g_ch
    logic [31:0] d;
    assign d = count_d(regs_q[2*g][11:6], regs_q[2*g][5:0], regs_q[2*g+1][6]);

    assign ch_div[g]   = flags_q[g] ? d : '0;
    assign ch_duty[g]  = !flags_q[g]        ? 32'd0   :
                         regs_q[2*g+1][6]   ? 32'd500 :
                         (32'd1000 * (32'd2 * field_val(regs_q[2*g][11:6]) +
                                      {31'd0, regs_q[2*g+1][7]})) / (32'd2 * d);
    assign ch_phase[g] = flags_q[g] ?
                         phase_deg(regs_q[2*g][15:13], regs_q[2*g+1][5:0], d) : '0;
  end

  // Feedback channel: only divide (as multiplier) and phase are consumed.
  logic [31:0] fb_d;
  assign fb_d = count_d(regs_q[14][11:6], regs_q[14][5:0], regs_q[15][6]);
  assign CLKFBOUT_MULT_F_1000 = flags_q[7] ? fb_d * 32'd1000 : '0;
  assign CLKFBOUT_PHASE       = flags_q[7] ?
                                phase_deg(regs_q[14][15:13], regs_q[15][5:0], fb_d) : '0;

  // Input divider: EDGE (bit 13) is stored for readback but not decoded.
  assign DIVCLK_DIVIDE = flags_q[8] ?
                         count_d(regs_q[16][11:6], regs_q[16][5:0], regs_q[16][12]) : '0;

  assign CLKOUT5_DIVIDE          = ch_div[0];
  assign CLKOUT5_DUTY_CYCLE_1000 = ch_duty[0];
  assign CLKOUT5_PHASE           = ch_phase[0];
  assign CLKOUT0_DIVIDE          = ch_div[1];
  assign CLKOUT0_DUTY_CYCLE_1000 = ch_duty[1];
  assign CLKOUT0_PHASE           = ch_phase[1];
  assign CLKOUT1_DIVIDE          = ch_div[2];
  assign CLKOUT1_DUTY_CYCLE_1000 = ch_duty[2];
  assign CLKOUT1_PHASE           = ch_phase[2];
  assign CLKOUT2_DIVIDE          = ch_div[3];
  assign CLKOUT2_DUTY_CYCLE_1000 = ch_duty[3];
  assign CLKOUT2_PHASE           = ch_phase[3];
  assign CLKOUT3_DIVIDE          = ch_div[4];
  assign CLKOUT3_DUTY_CYCLE_1000 = ch_duty[4];
  assign CLKOUT3_PHASE           = ch_phase[4];
  assign CLKOUT4_DIVIDE          = ch_div[5];
  assign CLKOUT4_DUTY_CYCLE_1000 = ch_duty[5];
  assign CLKOUT4_PHASE           = ch_phase[5];
  assign CLKOUT6_DIVIDE          = ch_div[6];
  assign CLKOUT6_DUTY_CYCLE_1000 = ch_duty[6];
  assign CLKOUT6_PHASE           = ch_phase[6];

endmodule

// File: tb/tb_pll_drp_regs.sv
// ---------------------------------------------------------------------------
// tb_pll_drp_regs
//   Directed bench for pll_drp_regs: reset state, channel decode of divide,
//   duty and phase, zero/NO_COUNT encodings, address map, readback and the
//   DRDY handshake including reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_pll_drp_regs;

  logic DCLK;
  logic RST;
  pll_drp_regs_if bus ();

  logic [31:0] div_o   [7];
  logic [31:0] duty_o  [7];
  logic [31:0] phase_o [7];
  logic [31:0] fb_mult, fb_phase, divclk;

  int errors = 0;
  int checks = 0;

  pll_drp_regs dut (
    .DCLK                    (DCLK),
    .RST                     (RST),
    .drp                     (bus),
    .CLKOUT0_DIVIDE          (div_o[0]),
    .CLKOUT0_DUTY_CYCLE_1000 (duty_o[0]),
    .CLKOUT0_PHASE           (phase_o[0]),
    .CLKOUT1_DIVIDE          (div_o[1]),
    .CLKOUT1_DUTY_CYCLE_1000 (duty_o[1]),
    .CLKOUT1_PHASE           (phase_o[1]),
    .CLKOUT2_DIVIDE          (div_o[2]),
    .CLKOUT2_DUTY_CYCLE_1000 (duty_o[2]),
    .CLKOUT2_PHASE           (phase_o[2]),
    .CLKOUT3_DIVIDE          (div_o[3]),
    .CLKOUT3_DUTY_CYCLE_1000 (duty_o[3]),
    .CLKOUT3_PHASE           (phase_o[3]),
    .CLKOUT4_DIVIDE          (div_o[4]),
    .CLKOUT4_DUTY_CYCLE_1000 (duty_o[4]),
    .CLKOUT4_PHASE           (phase_o[4]),
    .CLKOUT5_DIVIDE          (div_o[5]),
    .CLKOUT5_DUTY_CYCLE_1000 (duty_o[5]),
    .CLKOUT5_PHASE           (phase_o[5]),
    .CLKOUT6_DIVIDE          (div_o[6]),
    .CLKOUT6_DUTY_CYCLE_1000 (duty_o[6]),
    .CLKOUT6_PHASE           (phase_o[6]),
    .CLKFBOUT_MULT_F_1000    (fb_mult),
    .CLKFBOUT_PHASE          (fb_phase),
    .DIVCLK_DIVIDE           (divclk)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one access at the falling edge, then sample 1 ns after the rising
  // edge that accepts it (start of its DRDY cycle). DEN stays high.
  task automatic access(input logic [6:0] addr, input logic we, input logic [15:0] data);
    @(negedge DCLK);
    bus.DADDR = addr;
    bus.DEN   = 1'b1;
    bus.DWE   = we;
    bus.DI    = data;
    @(posedge DCLK);
    #1;
  endtask

  task automatic idle();
    @(negedge DCLK);
    bus.DEN = 1'b0;
    bus.DWE = 1'b0;
  endtask

  task automatic write(input logic [6:0] addr, input logic [15:0] data);
    access(addr, 1'b1, data);
    check($sformatf("wr_drdy_%0h", addr), {31'd0, bus.DRDY}, 32'd1);
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    for (int n = 0; n < 7; n++) begin
      check($sformatf("%s_div%0d", tag, n),   div_o[n],   32'd0);
      check($sformatf("%s_duty%0d", tag, n),  duty_o[n],  32'd0);
      check($sformatf("%s_phase%0d", tag, n), phase_o[n], 32'd0);
    end
    check({tag, "_fbmult"},  fb_mult,  32'd0);
    check({tag, "_fbphase"}, fb_phase, 32'd0);
    check({tag, "_divclk"},  divclk,   32'd0);
  endtask

  initial begin
    RST       = 1'b0;
    bus.DADDR = '0;
    bus.DEN   = 1'b0;
    bus.DWE   = 1'b0;
    bus.DI    = '0;

    // Reset state
    #22;
    check("rst_do",   {16'd0, bus.DO}, 32'd0);
    check("rst_drdy", {31'd0, bus.DRDY}, 32'd0);
    check_all_zero("rst");
    @(negedge DCLK);
    RST = 1'b1;

    // CLKOUT0: HIGH=1 LOW=1 -> divide 2, duty 500, phase 0
    write(7'h08, 16'h0041);
    write(7'h09, 16'h0000);
    check("c0_div",   div_o[0],   32'd2);
    check("c0_duty",  duty_o[0],  32'd500);
    check("c0_phase", phase_o[0], 32'd0);
    check("c1_div_unset",  div_o[1],  32'd0);
    check("c1_duty_unset", duty_o[1], 32'd0);

    // CLKOUT1: HIGH=3 LOW=2 EDGE=1 -> divide 5, duty 1000*7/10 = 700
    write(7'h0A, 16'h00C2);
    write(7'h0B, 16'h0080);
    check("c1_div",  div_o[1],  32'd5);
    check("c1_duty", duty_o[1], 32'd700);

    // CLKOUT2: MUX=1 HIGH=2 LOW=2 DELAY=1 -> divide 4, phase 405/4 = 101
    write(7'h0C, 16'h2082);
    write(7'h0D, 16'h0001);
    check("c2_div",   div_o[2],   32'd4);
    check("c2_phase", phase_o[2], 32'd101);
    check("c2_duty",  duty_o[2],  32'd500);

    // Feedback: only Reg2 written, NO_COUNT=1 -> multiplier 1000
    write(7'h15, 16'h0040);
    check("fb_mult",  fb_mult,  32'd1000);
    check("fb_phase", fb_phase, 32'd0);

    // DIVCLK: zero fields encode 64+64; then NO_COUNT forces 1
    write(7'h16, 16'h0000);
    check("divclk_128", divclk, 32'd128);
    write(7'h16, 16'h1000);
    check("divclk_1", divclk, 32'd1);

    // Address map: CLKOUT5 at 0x06, CLKOUT6 at 0x12 (HIGH=3 LOW=2 -> 600)
    write(7'h06, 16'h0041);
    check("c5_div",       div_o[5], 32'd2);
    check("c4_div_unset", div_o[4], 32'd0);
    write(7'h12, 16'h00C2);
    check("c6_div",  div_o[6],  32'd5);
    check("c6_duty", duty_o[6], 32'd600);

    // Back-to-back writes to CLKOUT4 keep DRDY high on both cycles
    access(7'h10, 1'b1, 16'h0082);
    check("b2b_drdy0", {31'd0, bus.DRDY}, 32'd1);
    access(7'h11, 1'b1, 16'h0000);
    check("b2b_drdy1", {31'd0, bus.DRDY}, 32'd1);
    idle();
    check("c4_div",  div_o[4],  32'd4);
    check("c4_duty", duty_o[4], 32'd500);
    check("c3_div_unset", div_o[3], 32'd0);

    // Readback of CLKOUT1 Reg1 with a single-cycle DRDY
    access(7'h0A, 1'b0, 16'h0000);
    check("rd0a_drdy", {31'd0, bus.DRDY}, 32'd1);
    check("rd0a_do",   {16'd0, bus.DO},   32'h00C2);
    idle();
    @(posedge DCLK);
    #1;
    check("rd0a_drdy_end", {31'd0, bus.DRDY}, 32'd0);
    check("rd0a_do_end",   {16'd0, bus.DO},   32'd0);

    // Unmapped address: write discarded, read returns 0 with DRDY
    write(7'h30, 16'hFFFF);
    access(7'h30, 1'b0, 16'h0000);
    check("rd30_drdy", {31'd0, bus.DRDY}, 32'd1);
    check("rd30_do",   {16'd0, bus.DO},   32'd0);
    idle();

    // Read directly after write returns the new value
    access(7'h0E, 1'b1, 16'h1234);
    access(7'h0E, 1'b0, 16'h0000);
    check("raw_do", {16'd0, bus.DO}, 32'h1234);
    idle();

    // Reset asserted during a read's DRDY cycle
    access(7'h0C, 1'b0, 16'h0000);
    check("rdrst_drdy", {31'd0, bus.DRDY}, 32'd1);
    check("rdrst_do",   {16'd0, bus.DO},   32'h2082);
    #1;
    RST = 1'b0;
    #1;
    check("midrst_drdy", {31'd0, bus.DRDY}, 32'd0);
    check("midrst_do",   {16'd0, bus.DO},   32'd0);
    check_all_zero("midrst");
    idle();
    @(negedge DCLK);
    RST = 1'b1;

    // Stored words were cleared by the reset
    access(7'h0A, 1'b0, 16'h0000);
    check("postrst_do", {16'd0, bus.DO}, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
